// File: rtl/program_loader.sv
// Program loader: streams a byte image into a 256x8 program memory, holds the
// core in reset until the image is complete, then serves mem[pc] to the core.
module program_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_data,
  input  logic          wr_last,
  input  logic          reload,
  input  logic [AW-1:0] pc,
  output logic [7:0]    input_ins,
  output logic          core_hold,
  output logic [AW:0]   prog_len,
  output logic          full_stop
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  state_t      r_state;
  state_t      w_next_state;
  logic [AW:0] r_prog_len;
  logic [AW:0] w_next_len;
  logic [AW:0] w_len_inc;
  logic        r_full_stop;
  logic        w_next_full;
  logic        w_accept;
  logic        w_in_run;
  logic [7:0]  r_mem [DEPTH];

  assign w_in_run  = (r_state == S_RUN);
  assign wr_ready  = ~w_in_run;
  assign core_hold = ~w_in_run;
  assign prog_len  = r_prog_len;
  assign full_stop = r_full_stop;
  assign w_len_inc = r_prog_len + 1'b1;

  // reload outranks a simultaneous accept, so the write is suppressed here too
  assign w_accept  = wr_valid & wr_ready & ~reload;

  always_comb begin
    w_next_state = r_state;
    w_next_len   = r_prog_len;
    w_next_full  = r_full_stop;
    unique case (r_state)
      S_IDLE, S_LOAD: begin
        if (reload) begin
          w_next_state = S_IDLE;
          w_next_len   = '0;
        end else if (w_accept) begin
          w_next_len = w_len_inc;
          if (wr_last) begin
            w_next_state = S_RUN;
          end else if (w_len_inc == LP_DEPTH) begin
            w_next_state = S_RUN;
            w_next_full  = 1'b1;
          end else begin
            w_next_state = S_LOAD;
          end
        end
      end
      S_RUN: begin
        if (reload) begin
          w_next_state = S_IDLE;
          w_next_len   = '0;
          w_next_full  = 1'b0;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge CLB) begin
    if (CLB) begin
      r_state     <= S_IDLE;
      r_prog_len  <= '0;
      r_full_stop <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_prog_len  <= w_next_len;
      r_full_stop <= w_next_full;
    end
  end

  // Memory is deliberately not reset; prog_len masks any stale contents.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_prog_len[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    input_ins = 8'h00;
    if (w_in_run && ({1'b0, pc} < r_prog_len)) begin
      input_ins = r_mem[pc];
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: behavioural image model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       CLB = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       reload = 1'b0;
  logic [7:0] pc = 8'h00;
  logic [7:0] input_ins;
  logic       core_hold;
  logic [8:0] prog_len;
  logic       full_stop;

  int checks = 0;
  int errors = 0;

  program_loader #(.DEPTH(256), .AW(8)) dut (
    .clk       (clk),
    .CLB       (CLB),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_last   (wr_last),
    .reload    (reload),
    .pc        (pc),
    .input_ins (input_ins),
    .core_hold (core_hold),
    .prog_len  (prog_len),
    .full_stop (full_stop)
  );

  always #5 clk = ~clk;

  // Image model: bytes land at the current length; the image is running once
  // it has been closed by wr_last or by filling all 256 entries.
  logic [7:0] m_mem [256];
  logic [8:0] m_len  = '0;
  logic       m_run  = 1'b0;
  logic       m_full = 1'b0;

  always @(posedge clk or posedge CLB) begin
    if (CLB) begin
      m_len  <= '0;
      m_run  <= 1'b0;
      m_full <= 1'b0;
    end else if (reload) begin
      m_len  <= '0;
      m_run  <= 1'b0;
      m_full <= 1'b0;
    end else if (wr_valid && !m_run) begin
      m_mem[m_len[7:0]] <= wr_data;
      m_len <= m_len + 9'd1;
      if (wr_last) begin
        m_run <= 1'b1;
      end else if (int'(m_len) + 1 == 256) begin
        m_run  <= 1'b1;
        m_full <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] exp_ins;
    exp_ins = (m_run && ({1'b0, pc} < m_len)) ? m_mem[pc] : 8'h00;
    chk("wr_ready",  32'(wr_ready),  32'(!m_run));
    chk("core_hold", 32'(core_hold), 32'(!m_run));
    chk("prog_len",  32'(prog_len),  32'(m_len));
    chk("full_stop", 32'(full_stop), 32'(m_full));
    chk("input_ins", 32'(input_ins), 32'(exp_ins));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic read_at(input string name, input logic [7:0] a, input logic [7:0] exp);
    pc = a;
    #1;
    chk(name, 32'(input_ins), 32'(exp));
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_wr_ready",  32'(wr_ready),  32'd1);
    chk("rst_prog_len",  32'(prog_len),  32'd0);
    chk("rst_full_stop", 32'(full_stop), 32'd0);
    chk("rst_input_ins", 32'(input_ins), 32'd0);
    CLB = 1'b0;
    tick();

    // three-byte image
    send(8'h1A, 1'b0);
    send(8'h2B, 1'b0);
    chk("hold_before_last", 32'(core_hold), 32'd1);
    send(8'h3C, 1'b1);
    chk("len3", 32'(prog_len), 32'd3);
    chk("hold_fall", 32'(core_hold), 32'd0);
    read_at("pc0", 8'd0, 8'h1A);
    read_at("pc1", 8'd1, 8'h2B);
    read_at("pc2", 8'd2, 8'h3C);
    read_at("pc3", 8'd3, 8'h00);

    // full-memory image
    do_reload();
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0);
    chk("full_flag", 32'(full_stop), 32'd1);
    chk("full_len",  32'(prog_len),  32'd256);
    chk("full_ready", 32'(wr_ready), 32'd0);
    read_at("full_pcFF", 8'hFF, 8'hFF);
    read_at("full_pc80", 8'h80, 8'h80);

    // reload then one-byte image over stale data
    do_reload();
    chk("reload_len", 32'(prog_len), 32'd0);
    send(8'h55, 1'b1);
    chk("one_len",  32'(prog_len),  32'd1);
    chk("one_full", 32'(full_stop), 32'd0);
    read_at("one_pc0", 8'd0, 8'h55);
    read_at("one_pc1", 8'd1, 8'h00);

    // asynchronous reset mid-load
    do_reload();
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0);
    #2;
    CLB = 1'b1;
    #1;
    chk("async_hold", 32'(core_hold), 32'd1);
    chk("async_len",  32'(prog_len),  32'd0);
    tick();
    CLB = 1'b0;
    tick();
    send(8'hAA, 1'b1);
    chk("restart_len", 32'(prog_len), 32'd1);
    read_at("restart_pc0", 8'd0, 8'hAA);

    // reload with a simultaneous valid byte in LOAD
    do_reload();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    wr_valid = 1'b1;
    wr_data  = 8'h33;
    reload   = 1'b1;
    tick();
    wr_valid = 1'b0;
    reload   = 1'b0;
    chk("reload_wins_len", 32'(prog_len), 32'd0);
    send(8'h44, 1'b0);
    send(8'h66, 1'b1);
    for (int i = 0; i < 4; i++) send(8'hEE, 1'(i & 1));
    chk("run_ignore_len", 32'(prog_len), 32'd2);
    read_at("run_ignore_pc0", 8'd0, 8'h44);
    read_at("run_ignore_pc1", 8'd1, 8'h66);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 199);
      pc       = 8'($urandom_range(0, 15));
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
      wr_last  = ($urandom_range(0, 11) == 0);
      reload   = (r < 4);
      if (r == 199) begin
        wr_valid = 1'b0;
        #2;
        CLB = 1'b1;
        tick();
        CLB = 1'b0;
      end else begin
        tick();
      end
    end
    wr_valid = 1'b0;
    reload   = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
